// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Contents: FSM state enum, legal byte-strobe patterns, LATENCY ceiling,
//           and the misaligned-store predicate used when DMEM_ALIGN_CHECK_EN
//           is defined.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] WE_READ = 4'b0000;
  localparam logic [3:0] SB_B0   = 4'b0001;
  localparam logic [3:0] SB_B1   = 4'b0010;
  localparam logic [3:0] SB_B2   = 4'b0100;
  localparam logic [3:0] SB_B3   = 4'b1000;
  localparam logic [3:0] SH_LO   = 4'b0011;
  localparam logic [3:0] SH_HI   = 4'b1100;
  localparam logic [3:0] SW      = 4'b1111;

  localparam int LATENCY_MAX = 7;

  // True when a strobe/address pair cannot come from a legal sb/sh/sw.
  function automatic logic store_illegal(input logic [3:0] we, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (we)
      WE_READ, SB_B0, SB_B1, SB_B2, SB_B3: bad = 1'b0;
      SH_LO, SH_HI:                        bad = addr_lo[0];
      SW:                                  bad = (addr_lo != 2'b00);
      default:                             bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-to-memory data bus carried between the mem stage and dmem_responder.
// master modport: the core (drives request, strobes, address, store data).
// slave modport:  the responder (drives read data, ready, stall, err).
interface dmem_responder_if;
  logic        req_i;
  logic [3:0]  we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ready_o;
  logic        stall_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ready_o, stall_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ready_o, stall_o, err_o
  );
endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port word storage with per-byte write enables.
// Ports:
//   clk   - rising-edge clock
//   en    - access strobe; read and (masked) write happen on this edge
//   idx   - word index
//   we    - byte-lane write enables
//   wdata - store data, lanes already positioned
//   rdata - registered read data, pre-write contents (read-before-write)
// No reset: contents and output register are left as they are.
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] idx,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  // One byte-wide memory per lane keeps each lane a plain inferable RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rd_reg;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[gi]) begin
          mem[idx] <= wdata[gi*8 +: 8];
        end
        rd_reg <= mem[idx];
      end
    end

    assign rdata[gi*8 +: 8] = rd_reg;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the CPU mem-stage data interface.
// Accepts one request at a time, stalls for LATENCY wait states, then
// completes with a one-cycle ready_o pulse and registered read data.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - dmem_responder_if.slave (req/we/addr/wdata in; rdata/ready/stall/err out)
// Parameters: ADDR_W (word-index width), LATENCY (wait states, 0..7).
// Optional feature: define DMEM_ALIGN_CHECK_EN to suppress and flag
// misaligned or malformed stores via err_o; otherwise err_o is 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  state_t            state_reg;
  logic [2:0]        cnt_reg;
  logic [ADDR_W+1:0] addr_reg;
  logic [3:0]        we_reg;
  logic [31:0]       wdata_reg;
  logic              ready_reg;
  logic              err_reg;
  logic              valid_reg;

  logic [ADDR_W+1:0] acc_addr;
  logic [3:0]        acc_we;
  logic [31:0]       acc_wdata;
  logic              enter_done;
  logic              illegal;
  logic [31:0]       arr_rdata;
  logic              unused_bits;

  // With LATENCY=0 the access happens on the acceptance edge, before the
  // latch is loaded, so the live (held-stable) bus inputs are used then.
  assign acc_addr  = (state_reg == IDLE) ? bus.addr_i[ADDR_W+1:0] : addr_reg;
  assign acc_we    = (state_reg == IDLE) ? bus.we_i : we_reg;
  assign acc_wdata = (state_reg == IDLE) ? bus.wdata_i : wdata_reg;

  assign enter_done = ((state_reg == IDLE) && bus.req_i && (LATENCY == 0)) ||
                      ((state_reg == WAIT) && (cnt_reg == 3'd0));

`ifdef DMEM_ALIGN_CHECK_EN
  assign illegal = store_illegal(acc_we, acc_addr[1:0]);
`else
  assign illegal = 1'b0;
`endif

  // Upper address bits alias by design; byte offset only matters to the check.
  assign unused_bits = ^{bus.addr_i[31:ADDR_W+2], acc_addr[1:0]};

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .en    (enter_done),
    .idx   (acc_addr[ADDR_W+1:2]),
    .we    (acc_we & {4{~illegal}}),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      addr_reg  <= '0;
      we_reg    <= 4'b0000;
      wdata_reg <= 32'h0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_i) begin
            addr_reg  <= bus.addr_i[ADDR_W+1:0];
            we_reg    <= bus.we_i;
            wdata_reg <= bus.wdata_i;
            if (LATENCY == 0) begin
              state_reg <= DONE;
              ready_reg <= 1'b1;
              err_reg   <= illegal;
              valid_reg <= 1'b1;
            end else begin
              cnt_reg   <= 3'(LATENCY - 1);
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 3'd0) begin
            state_reg <= DONE;
            ready_reg <= 1'b1;
            err_reg   <= illegal;
            valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        DONE: begin
          // Any req_i seen here belongs to the request now completing.
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ready_o = ready_reg;
  assign bus.err_o   = err_reg;
  assign bus.stall_o = ((state_reg == IDLE) && bus.req_i) || (state_reg == WAIT);
  // The array output register has no reset; read data reads as 0 until the
  // first completion after reset.
  assign bus.rdata_o = valid_reg ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          d;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vec [13];

  // Reference storage: one word array per DUT, indexed by word.
  logic [31:0] model [2][1024];

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input int d, input logic req, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (d == 0) begin
      bus0.req_i = req; bus0.we_i = we; bus0.addr_i = addr; bus0.wdata_i = wdata;
    end else begin
      bus1.req_i = req; bus1.we_i = we; bus1.addr_i = addr; bus1.wdata_i = wdata;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after completion.
  task automatic access(input int d, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int cycles, output int stalls);
    logic st, rd;
    drive(d, 1'b1, we, addr, wdata);
    cycles = 0; stalls = 0; rdata = '0; err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      cycles++;
      st = (d == 0) ? bus0.stall_o : bus1.stall_o;
      rd = (d == 0) ? bus0.ready_o : bus1.ready_o;
      if (st) stalls++;
      if (rd) begin
        rdata = (d == 0) ? bus0.rdata_o : bus1.rdata_o;
        err   = (d == 0) ? bus0.err_o : bus1.err_o;
        break;
      end
      @(negedge clk);
    end
    drive(d, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic run_txn(input string name, input int d, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit chk_rd, input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] rdata;
    logic err;
    int cycles, stalls;
    access(d, we, addr, wdata, rdata, err, cycles, stalls);
    $display("txn %s dut%0d we=%b addr=%h wdata=%h rdata=%h err=%b cycles=%0d stalls=%0d",
             name, d, we, addr, wdata, rdata, err, cycles, stalls);
    if (chk_rd) chk({name, " rdata"}, rdata, exp_rd);
    chk({name, " err"}, 32'(err), 32'(exp_err));
    chk({name, " cycles"}, cycles, lat(d) + 2);
    chk({name, " stalls"}, stalls, lat(d) + 1);
  endtask

  function automatic bit model_illegal(input logic [3:0] we, input logic [1:0] lo);
    if (!ALIGN) return 1'b0;
    if (!(we inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                     4'b0011, 4'b1100, 4'b1111})) return 1'b1;
    if (we == 4'b1111 && lo != 2'b00) return 1'b1;
    if ((we == 4'b0011 || we == 4'b1100) && lo[0]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference transaction: read-before-write on the aliased word.
  task automatic model_txn(input string name, input int d, input logic [3:0] we,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit chk_rd);
    int idx;
    logic [31:0] old_w, new_w;
    bit bad;
    idx   = (addr / 4) % 1024;
    old_w = model[d][idx];
    bad   = (we != 4'b0000) && model_illegal(we, addr[1:0]);
    new_w = old_w;
    if (!bad)
      for (int k = 0; k < 4; k++)
        if (we[k]) new_w[k*8 +: 8] = wdata[k*8 +: 8];
    model[d][idx] = new_w;
    run_txn(name, d, we, addr, wdata, chk_rd, old_w, bad);
  endtask

  logic [3:0] we_pool [14] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF,
                               4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hE};

  initial begin
    vec[0]  = '{0, 4'hF, 32'h10,   32'hDEADBEEF, 0, 32'h0,        0};
    vec[1]  = '{0, 4'h0, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0};
    vec[2]  = '{0, 4'h2, 32'h10,   32'h0000AA00, 1, 32'hDEADBEEF, 0};
    vec[3]  = '{0, 4'h0, 32'h10,   32'h0,        1, 32'hDEADAAEF, 0};
    vec[4]  = '{0, 4'hF, 32'h20,   32'hCAFEF00D, 0, 32'h0,        0};
    vec[5]  = '{0, 4'hF, 32'h22,   32'h12345678, 1, 32'hCAFEF00D, ALIGN};
    vec[6]  = '{0, 4'h0, 32'h20,   32'h0,        1, ALIGN ? 32'hCAFEF00D : 32'h12345678, 0};
    vec[7]  = '{0, 4'hF, 32'h1004, 32'h11223344, 0, 32'h0,        0};
    vec[8]  = '{0, 4'h0, 32'h0004, 32'h0,        1, 32'h11223344, 0};
    vec[9]  = '{1, 4'hF, 32'h0,    32'hA5A5A5A5, 0, 32'h0,        0};
    vec[10] = '{1, 4'hF, 32'h4,    32'h5A5A5A5A, 0, 32'h0,        0};
    vec[11] = '{1, 4'h0, 32'h0,    32'h0,        1, 32'hA5A5A5A5, 0};
    vec[12] = '{1, 4'h0, 32'h4,    32'h0,        1, 32'h5A5A5A5A, 0};

    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset ready", 32'(bus0.ready_o), 32'h0);
    chk("reset err", 32'(bus0.err_o), 32'h0);
    chk("reset rdata", bus0.rdata_o, 32'h0);
    chk("reset stall", 32'(bus0.stall_o), 32'h0);
    chk("reset ready lat0", 32'(bus1.ready_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 13; i++)
      run_txn($sformatf("vec%0d", i), vec[i].d, vec[i].we, vec[i].addr, vec[i].wdata,
              vec[i].chk_rd, vec[i].exp_rd, vec[i].exp_err);

    // Read data must hold after the ready pulse
    repeat (3) @(negedge clk);
    #1;
    chk("rdata hold", bus1.rdata_o, 32'h5A5A5A5A);
    @(negedge clk);

    // Reset in the middle of a write's wait states
    run_txn("rst_pre", 0, 4'hF, 32'h30, 32'h0BADF00D, 0, 32'h0, 0);
    drive(0, 1'b1, 4'hF, 32'h30, 32'h12345678);
    @(negedge clk);
    #1;
    chk("rst_mid stall in wait", 32'(bus0.stall_o), 32'h1);
    rst = 1'b0;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("rst_mid ready", 32'(bus0.ready_o), 32'h0);
    chk("rst_mid err", 32'(bus0.err_o), 32'h0);
    chk("rst_mid rdata", bus0.rdata_o, 32'h0);
    chk("rst_mid stall", 32'(bus0.stall_o), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid idle after", 32'(bus0.stall_o | bus0.ready_o), 32'h0);
    @(negedge clk);
    run_txn("rst_post", 0, 4'h0, 32'h30, 32'h0, 1, 32'h0BADF00D, 0);

    // Randomized traffic against the reference model
    for (int d = 0; d < 2; d++) begin
      for (int w = 64; w < 72; w++)
        model_txn($sformatf("init%0d", w), d, 4'hF, 32'(w * 4), $urandom, 0);
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a;
        a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(64, 71)) << 2) |
            32'($urandom_range(0, 3));
        model_txn($sformatf("rnd%0d", i), d, we_pool[$urandom_range(0, 13)], a, $urandom, 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the CPU memory-stage data interface.
- Accepts one word-addressed load/store request at a time, inserts LATENCY wait states while asserting stall_o to hold the pipeline, then completes with a one-cycle ready_o pulse and registered read data.
- Supports byte-lane writes for sb/sh/sw.
- Sits between the core's mem stage (address/write data out, read data in) and on-chip data storage.

Parameters:
- ADDR_W, 10, word-index width; storage depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, wait-state cycles between acceptance and completion; legal range 0..7.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_i  in  1  access request, held stable by the core until ready_o
- we_i  in  4  byte write strobes; 4'b0000 = read
- addr_i  in  32  byte address
- wdata_i  in  32  store data, byte lanes already positioned by the core
- rdata_o  out  32  word read data, valid when ready_o=1
- ready_o  out  1  one-cycle completion pulse
- stall_o  out  1  hold request to the pipeline
- err_o  out  1  misaligned-store flag; only meaningful with the optional feature

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, rdata_o=0, ready_o=0, err_o=0. Storage contents are not cleared.
- States: IDLE, WAIT, DONE.
- IDLE, req_i=1: latch addr_i/we_i/wdata_i.
  - LATENCY>0: counter=LATENCY-1, go to WAIT.
  - LATENCY=0: go to DONE.
- IDLE, req_i=0: remain in IDLE.
- WAIT: decrement counter each cycle. When counter==0, go to DONE on the next edge.
- Storage access happens on the edge entering DONE, using the latched request:
  - Word index = addr[ADDR_W+1:2]. Upper address bits are ignored and alias.
  - Byte lane k is written when we[k]=1.
  - rdata_o is registered with the pre-write word at that index (read-before-write). A read, we=0, returns the current word.
- DONE: ready_o=1 for exactly this cycle. Always return to IDLE next cycle; req_i seen during DONE is the completing request and is ignored.
- rdata_o holds its value until the next entry to DONE.
- stall_o = (IDLE & req_i) | WAIT. stall_o is low in DONE, so the pipeline advances on the DONE edge.
- Total occupancy per access: LATENCY+2 cycles, with LATENCY+1 of them stalled.
- Consecutive requests are serialized. A read following a write to the same word returns the merged written data.
- Reset mid-WAIT: abort; no write is performed; return to IDLE.
- req_i dropped mid-WAIT: protocol violation. The latched request still completes.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN
- Defined: a latched store is illegal if any of these hold:
  - we = 4'b1111 with addr[1:0]≠0
  - we ∈ {4'b0011, 4'b1100} with addr[0]≠0
  - we not in {0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111}
- For an illegal store: the write is suppressed, and err_o=1 in the DONE cycle alongside ready_o. Reads are never flagged.
- Not defined: err_o tied to 0, and every strobe pattern is written as given.

Decomposition:
- Package dmem_pkg:
  - state enum (IDLE/WAIT/DONE)
  - legal strobe constants (SB lanes, SH_LO, SH_HI, SW)
  - LATENCY maximum constant
- Sub-module dmem_array:
  - synchronous single-port storage
  - per-byte write enables
  - read-before-write registered output
  - no reset
- dmem_responder holds the FSM, wait counter, request latch and alignment check.

Test Plan:
- LATENCY=2; write we=1111 addr=0x10 wdata=0xDEADBEEF → stall_o high 3 cycles, ready_o on cycle 4; then read addr=0x10 → rdata_o=0xDEADBEEF with ready_o.
- Byte merge: word 0x10=0xDEADBEEF; write we=0010 wdata=0x0000AA00 → subsequent read returns 0xDEADAABE... correction: returns 0xDEADAAEF.
- LATENCY=0; back-to-back reads of addr 0x0 then 0x4 → each completes in 2 cycles; stall_o high only in the IDLE acceptance cycle; no request lost.
- Reset asserted during WAIT of a write 0x12345678 to addr 0x20 → state IDLE, outputs 0; later read of 0x20 returns the old value, not 0x12345678.
- DMEM_ALIGN_CHECK_EN: write we=1111 addr=0x22 → err_o=1 with ready_o; word 0x20 unchanged. Without the macro: err_o=0.
- Aliasing, ADDR_W=10: write addr=0x1004 then read addr=0x0004 → same data returned.
